// File: rtl/minigpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | minigpu_pkg : shared R-type opcode/funct constants, issue FSM states  |
// |               and the decode legality helper                         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package minigpu_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_ERR  = 2'd3
  } issue_state_e;

  // Operand/destination fields of an R-type word, opcode stripped.
  typedef struct packed {
    logic [6:0] f7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] f3;
    logic [4:0] rd;
  } rtype_t;

  function automatic rtype_t split_rtype(input logic [31:0] word);
    rtype_t f;
    f.f7  = word[31:25];
    f.rs2 = word[24:20];
    f.rs1 = word[19:15];
    f.f3  = word[14:12];
    f.rd  = word[11:7];
    return f;
  endfunction

  function automatic logic is_legal_rtype(input logic [31:0] word);
    logic ok;
    ok = 1'b0;
    if (word[6:0] == OPC_RTYPE) begin
      case ({word[31:25], word[14:12]})
        {F7_BASE, F3_ADDSUB},
        {F7_SUB,  F3_ADDSUB},
        {F7_MUL,  F3_ADDSUB},
        {F7_BASE, F3_XOR},
        {F7_BASE, F3_OR},
        {F7_BASE, F3_AND}: ok = 1'b1;
        default:           ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_if : instruction handshake, ALU operand/result, preload,   |
// |                debug read and retire/illegal status bundle           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_issue_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;

  logic [DW-1:0] alu_rs1;
  logic [DW-1:0] alu_rs2;
  logic [2:0]    alu_f3;
  logic [6:0]    alu_f7;
  logic [DW-1:0] alu_rd;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  logic          retire;
  logic [AW-1:0] retire_rd;
  logic          illegal;

  modport slave (
    input  inst_valid, inst, alu_rd, ld_en, ld_addr, ld_data, dbg_addr,
    output inst_ready, alu_rs1, alu_rs2, alu_f3, alu_f7, dbg_data,
           retire, retire_rd, illegal
  );

  modport master (
    output inst_valid, inst, alu_rd, ld_en, ld_addr, ld_data, dbg_addr,
    input  inst_ready, alu_rs1, alu_rs2, alu_f3, alu_f7, dbg_data,
           retire, retire_rd, illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_issue_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_regfile : NREGS x DW registers, one write port, two operand|
// |                     read ports and a debug read port; x0 reads zero  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_issue_regfile #(
  parameter int DW    = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire logic [DW-1:0] wdata,
  input  wire logic [AW-1:0] ra1,
  output logic      [DW-1:0] rd1,
  input  wire logic [AW-1:0] ra2,
  output logic      [DW-1:0] rd2,
  input  wire logic [AW-1:0] ra3,
  output logic      [DW-1:0] rd3
);

  logic [NREGS-1:0][DW-1:0] mem_q;
  logic [NREGS-1:0][DW-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the state after the last edge only; nothing in flight is bypassed.
  assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];
  assign rd3 = (ra3 == '0) ? '0 : mem_q[ra3];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue : decode-and-issue sequencer feeding the combinational ALU |
// |             (IDLE -> EXEC -> WB, or IDLE -> ERR for illegal words)   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_issue
  import minigpu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  wire logic  clk,
  input  wire logic  rst,
  alu_issue_if.slave bus
);

  issue_state_e  state_q;
  issue_state_e  state_d;
  rtype_t        fields_q;
  rtype_t        fields_d;
  logic [DW-1:0] result_q;
  logic [DW-1:0] result_d;

  logic          in_idle;
  logic          in_exec;
  logic          in_wb;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;

  assign in_idle = (state_q == ST_IDLE);
  assign in_exec = (state_q == ST_EXEC);
  assign in_wb   = (state_q == ST_WB);

  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.inst_valid) begin
          fields_d = split_rtype(bus.inst);
          state_d  = is_legal_rtype(bus.inst) ? ST_EXEC : ST_ERR;
        end
      end
      ST_EXEC: begin
        result_d = bus.alu_rd;
        state_d  = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      fields_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      result_q <= result_d;
    end
  end

  // Preload and writeback live in disjoint states, so one write port suffices.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (in_wb) begin
      rf_we    = (fields_q.rd != '0);
      rf_waddr = fields_q.rd;
      rf_wdata = result_q;
    end else if (in_idle && bus.ld_en) begin
      rf_we    = (bus.ld_addr != '0);
      rf_waddr = bus.ld_addr;
      rf_wdata = bus.ld_data;
    end
  end

  alu_issue_regfile #(
    .DW    (DW),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .ra1   (fields_q.rs1),
    .rd1   (rf_rd1),
    .ra2   (fields_q.rs2),
    .rd2   (rf_rd2),
    .ra3   (bus.dbg_addr),
    .rd3   (bus.dbg_data)
  );

  assign bus.inst_ready = in_idle;

  assign bus.alu_rs1 = in_exec ? rf_rd1      : '0;
  assign bus.alu_rs2 = in_exec ? rf_rd2      : '0;
  assign bus.alu_f3  = in_exec ? fields_q.f3 : 3'b000;
  assign bus.alu_f7  = in_exec ? fields_q.f7 : 7'b0000000;

  assign bus.retire    = in_wb;
  assign bus.retire_rd = in_wb ? fields_q.rd : '0;
  assign bus.illegal   = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue : directed scoreboard bench for alu_issue with a        |
// |                behavioural ALU closing the operand/result loop       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_issue;
  import minigpu_pkg::*;

  logic clk;
  logic rst;

  alu_issue_if #(.DW(32), .AW(5)) bus ();

  alu_issue #(.DW(32), .NREGS(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.alu_rd = 32'h0;
    if (bus.alu_f3 == F3_ADDSUB && bus.alu_f7 == F7_BASE) bus.alu_rd = bus.alu_rs1 + bus.alu_rs2;
    else if (bus.alu_f3 == F3_ADDSUB && bus.alu_f7 == F7_SUB) bus.alu_rd = bus.alu_rs1 - bus.alu_rs2;
    else if (bus.alu_f3 == F3_ADDSUB && bus.alu_f7 == F7_MUL) bus.alu_rd = bus.alu_rs1 * bus.alu_rs2;
    else if (bus.alu_f3 == F3_XOR) bus.alu_rd = bus.alu_rs1 ^ bus.alu_rs2;
    else if (bus.alu_f3 == F3_OR)  bus.alu_rd = bus.alu_rs1 | bus.alu_rs2;
    else if (bus.alu_f3 == F3_AND) bus.alu_rd = bus.alu_rs1 & bus.alu_rs2;
  end

  typedef struct packed {
    logic        legal;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = i[4:0];
      #1;
      chk($sformatf("%s/x%0d", tag, i), bus.dbg_data, model[i]);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  // ld_mode: 0 none, 1 preload in the accept cycle, 2 preload attempt during EXEC.
  task automatic issue(input string tag, input logic [31:0] word, input logic legal,
                       input logic [31:0] exp_val, input int ld_mode,
                       input logic [4:0] ld_a, input logic [31:0] ld_d);
    exp_t e;
    int   k;
    logic [31:0] dbg_exp;
    e.legal = legal;
    e.rd    = word[11:7];
    e.val   = exp_val;
    sb.push_back(e);

    @(negedge clk);
    chk({tag, "/ready_idle"}, bus.inst_ready, 1);
    bus.inst_valid = 1'b1;
    bus.inst       = word;
    if (ld_mode == 1) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = ld_a;
      bus.ld_data = ld_d;
      if (ld_a != 5'd0) model[ld_a] = ld_d;
    end

    @(negedge clk);
    bus.inst_valid = 1'b0;
    bus.inst       = $urandom();
    bus.ld_en      = 1'b0;
    chk({tag, "/ready_busy"}, bus.inst_ready, 0);
    if (legal) begin
      chk({tag, "/alu_rs1"}, bus.alu_rs1, model[word[19:15]]);
      chk({tag, "/alu_rs2"}, bus.alu_rs2, model[word[24:20]]);
      chk({tag, "/alu_f3"},  bus.alu_f3,  word[14:12]);
      chk({tag, "/alu_f7"},  bus.alu_f7,  word[31:25]);
    end else begin
      chk({tag, "/alu_rs1_idle"}, bus.alu_rs1, 0);
    end
    if (ld_mode == 2) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = ld_a;
      bus.ld_data = ld_d;
    end

    k = 0;
    while (!(bus.retire || bus.illegal) && k < 6) begin
      @(negedge clk);
      bus.ld_en = 1'b0;
      k++;
    end
    chk({tag, "/pulse_seen"}, bus.retire | bus.illegal, 1);
    e = sb.pop_front();
    chk({tag, "/retire"},  bus.retire,  e.legal);
    chk({tag, "/illegal"}, bus.illegal, !e.legal);
    chk({tag, "/latency"}, k, e.legal ? 1 : 0);
    if (e.legal) begin
      chk({tag, "/retire_rd"}, bus.retire_rd, e.rd);
      if (e.rd != 5'd0) model[e.rd] = e.val;
    end

    @(negedge clk);
    chk({tag, "/ready_back"}, bus.inst_ready, 1);
    chk({tag, "/pulse_end"}, bus.retire | bus.illegal, 0);
    bus.dbg_addr = e.rd;
    #1;
    dbg_exp = (e.legal && e.rd != 5'd0) ? e.val : model[e.rd];
    chk({tag, "/dbg_rd"}, bus.dbg_data, dbg_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [31:0] words [3];
    logic        legals [3];
    logic [31:0] vals [3];
    int          idx;
    int          pulses;

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst            = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst       = 32'h0;
    bus.ld_en      = 1'b0;
    bus.ld_addr    = 5'd0;
    bus.ld_data    = 32'h0;
    bus.dbg_addr   = 5'd0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/ready",     bus.inst_ready, 1);
    chk("rst/retire",    bus.retire,     0);
    chk("rst/illegal",   bus.illegal,    0);
    chk("rst/retire_rd", bus.retire_rd,  0);
    chk("rst/alu_rs1",   bus.alu_rs1,    0);
    chk("rst/alu_rs2",   bus.alu_rs2,    0);
    chk("rst/alu_f3",    bus.alu_f3,     0);
    chk("rst/alu_f7",    bus.alu_f7,     0);
    check_all_regs("rst");

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    issue("add", 32'h002081B3, 1'b1, 32'd8, 0, 5'd0, 32'h0);
    issue("sub", 32'h40110233, 1'b1, 32'hFFFF_FFFE, 0, 5'd0, 32'h0);

    preload(5'd1, 32'h0001_0000);
    preload(5'd2, 32'h0001_0000);
    issue("mul", enc_r(F7_MUL, 5'd2, 5'd1, F3_ADDSUB, 5'd5), 1'b1, 32'h0, 0, 5'd0, 32'h0);

    preload(5'd1, 32'hF0F0_F0F0);
    preload(5'd2, 32'hFF00_FF00);
    issue("xor", enc_r(F7_BASE, 5'd2, 5'd1, F3_XOR, 5'd6), 1'b1, 32'h0FF0_0FF0, 0, 5'd0, 32'h0);
    issue("or",  enc_r(F7_BASE, 5'd2, 5'd1, F3_OR,  5'd7), 1'b1, 32'hFFF0_FFF0, 0, 5'd0, 32'h0);
    issue("and", enc_r(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd8), 1'b1, 32'hF000_F000, 0, 5'd0, 32'h0);

    issue("ill_f7",  enc_r(F7_SUB, 5'd2, 5'd1, F3_XOR, 5'd9), 1'b0, 32'h0, 0, 5'd0, 32'h0);
    issue("ill_opc", 32'h0050_8513, 1'b0, 32'h0, 0, 5'd0, 32'h0);
    check_all_regs("after_ill");

    issue("add_x0", enc_r(F7_BASE, 5'd2, 5'd1, F3_ADDSUB, 5'd0), 1'b1, 32'h0, 0, 5'd0, 32'h0);
    issue("ld_exec", enc_r(F7_BASE, 5'd2, 5'd1, F3_ADDSUB, 5'd11), 1'b1, 32'hEFF1_EFF0,
          2, 5'd1, 32'h0000_DEAD);
    issue("ld_accept", enc_r(F7_BASE, 5'd2, 5'd1, F3_ADDSUB, 5'd12), 1'b1, 32'hF0F0_F0F1,
          1, 5'd2, 32'h0000_0001);
    check_all_regs("after_ld");

    // Reset while the ADD to x6 is executing.
    @(negedge clk);
    bus.inst_valid = 1'b1;
    bus.inst       = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADDSUB, 5'd6);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    chk("abort/in_exec", bus.inst_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort/ready", bus.inst_ready, 1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort/no_retire%0d", c), bus.retire, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    check_all_regs("abort");

    // Valid held high across busy cycles: each word must be taken once.
    preload(5'd1, 32'd7);
    preload(5'd2, 32'd9);
    words[0] = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADDSUB, 5'd7); legals[0] = 1'b1; vals[0] = 32'd16;
    words[1] = 32'h0010_8093;                             legals[1] = 1'b0; vals[1] = 32'd0;
    words[2] = enc_r(F7_SUB,  5'd1, 5'd7, F3_ADDSUB, 5'd8); legals[2] = 1'b1; vals[2] = 32'd9;
    idx    = 0;
    pulses = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus.retire || bus.illegal) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("b2b/kind%0d", pulses), bus.retire, e.legal);
          if (e.legal) begin
            chk($sformatf("b2b/rd%0d", pulses), bus.retire_rd, e.rd);
            if (e.rd != 5'd0) model[e.rd] = e.val;
          end
        end
      end
      if (bus.inst_ready) begin
        if (idx < 3) begin
          bus.inst_valid = 1'b1;
          bus.inst       = words[idx];
          e.legal = legals[idx];
          e.rd    = words[idx][11:7];
          e.val   = vals[idx];
          sb.push_back(e);
          idx++;
        end else begin
          bus.inst_valid = 1'b0;
        end
      end
    end
    bus.inst_valid = 1'b0;
    chk("b2b/pulses", pulses, 3);
    chk("b2b/sb_empty", sb.size(), 0);
    check_all_regs("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
